// File: rtl/spi_memory_burst.sv
// SPI mode-0 slave memory with burst transfers, address auto-increment/wrap,
// MISO output-enable and a bit-0 fault-injection switch for lab debugging.
module spi_memory_burst #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk_pin,
  input  logic       cs_pin,
  input  logic       mosi_pin,
  input  logic       fault_inject,
  output logic       miso_pin,
  output logic       miso_oe,
  output logic [7:0] leds
);

  localparam int CMD_W  = ADDR_W + 1;
  localparam int MAX_W  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
  localparam int CNT_W  = $clog2(MAX_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int WRAPS  = (2 ** ADDR_W) / DEPTH;
  localparam bit FULL   = (DEPTH == (2 ** ADDR_W));
  localparam int LED_N  = (DATA_W < 8) ? DATA_W : 8;

  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_LOAD,
    RD_SHIFT,
    WR_SHIFT,
    WR_STORE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   cmd_sr;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   sr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;

  logic              sclk_s;
  logic              cs_s;
  logic              mosi_s;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              cs_rise;
  logic              cs_fall;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] shift_in;
  logic [7:0]        leds_word;

  // Pin synchronisers reset to the idle bus levels so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_pin};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_pin};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_pin};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  assign next_addr = (addr_reg == ADDR_LAST) ? '0 : addr_reg + ADDR_W'(1);
  assign wr_word   = sr ^ DATA_W'(fault_inject);
  assign shift_in  = (sr << 1) | DATA_W'(mosi_s);

  always_comb begin
    leds_word = '0;
    for (int i = 0; i < LED_N; i++) begin
      leds_word[i] = wr_word[i];
    end
  end

  // Out-of-range command addresses fold back into the array by repeated subtraction.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] v;
    v = a;
    if (!FULL) begin
      for (int i = 0; i < WRAPS; i++) begin
        if (v >= ADDR_W'(DEPTH)) begin
          v = v - ADDR_W'(DEPTH);
        end
      end
    end
    return v;
  endfunction

  // WR_STORE always completes, even if cs rises in that same cycle.
  always_ff @(posedge clk) begin
    if (!reset && state == WR_STORE) begin
      mem[addr_reg[IDX_W-1:0]] <= wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      cmd_sr   <= '0;
      sr       <= '0;
      addr_reg <= '0;
      miso_pin <= 1'b0;
      miso_oe  <= 1'b0;
      leds     <= '0;
    end else if (cs_rise) begin
      if (state == WR_STORE) begin
        leds <= leds_word;
      end
      state    <= IDLE;
      bit_cnt  <= '0;
      miso_pin <= 1'b0;
      miso_oe  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          miso_oe <= 1'b0;
          if (cs_fall) begin
            state <= CMD;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_sr <= (cmd_sr << 1) | ADDR_W'(mosi_s);
            if (bit_cnt == CMD_LAST) begin
              bit_cnt  <= '0;
              addr_reg <= wrap_addr(cmd_sr);
              state    <= mosi_s ? RD_LOAD : WR_SHIFT;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        RD_LOAD: begin
          sr      <= mem[addr_reg[IDX_W-1:0]];
          miso_oe <= 1'b1;
          state   <= RD_SHIFT;
        end
        RD_SHIFT: begin
          if (sclk_fall) begin
            miso_pin <= sr[DATA_W-1];
            sr       <= sr << 1;
          end
          if (sclk_rise) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt  <= '0;
              addr_reg <= next_addr;
              state    <= RD_LOAD;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        WR_SHIFT: begin
          if (sclk_rise) begin
            sr <= shift_in;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= WR_STORE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        WR_STORE: begin
          leds     <= leds_word;
          addr_reg <= next_addr;
          state    <= WR_SHIFT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_memory_burst.sv
// Bench for spi_memory_burst: a default instance and a 16-bit/10-deep instance
// share sclk/mosi, each with its own chip select, checked against an array model.
module tb_spi_memory_burst;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk;
  logic       mosi;
  logic       fault;
  logic       cs0;
  logic       cs1;
  logic       miso0;
  logic       oe0;
  logic       miso1;
  logic       oe1;
  logic [7:0] leds0;
  logic [7:0] leds1;

  int checks = 0;
  int passes = 0;

  logic [31:0] tx_words [8];
  logic [31:0] rx_words [8];
  int          oe_bad;
  int          cmd_oe_bad;

  logic [31:0] model_mem0 [128];
  logic [31:0] model_mem1 [10];
  logic [7:0]  model_leds0;
  logic [7:0]  model_leds1;

  always #5 clk = ~clk;

  spi_memory_burst #(.ADDR_W(7), .DATA_W(8), .DEPTH(128), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .sclk_pin(sclk), .cs_pin(cs0), .mosi_pin(mosi),
    .fault_inject(fault), .miso_pin(miso0), .miso_oe(oe0), .leds(leds0)
  );

  spi_memory_burst #(.ADDR_W(4), .DATA_W(16), .DEPTH(10), .SYNC_STAGES(3)) u_dut_p (
    .clk(clk), .reset(reset), .sclk_pin(sclk), .cs_pin(cs1), .mosi_pin(mosi),
    .fault_inject(fault), .miso_pin(miso1), .miso_oe(oe1), .leds(leds1)
  );

  // One SPI bit: mosi set in the low phase, miso sampled just before the rise.
  task automatic drive_bit(input int sel, input logic mv, output logic sm, output logic so);
    mosi = mv;
    repeat (HALF) @(posedge clk);
    #1;
    sm = sel ? miso1 : miso0;
    so = sel ? oe1 : oe0;
    sclk = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    sclk = 1'b0;
  endtask

  task automatic set_cs(input int sel, input logic v);
    if (sel != 0) cs1 = v;
    else cs0 = v;
  endtask

  task automatic spi_txn(input int sel, input logic [31:0] addr, input bit rw,
                         input int nwords, input int abort_bits);
    int   aw;
    int   dw;
    int   sent;
    logic m;
    logic o;
    aw = (sel != 0) ? 4 : 7;
    dw = (sel != 0) ? 16 : 8;
    oe_bad = 0;
    cmd_oe_bad = 0;
    sent = 0;
    set_cs(sel, 1'b0);
    repeat (HALF) @(posedge clk);
    #1;
    for (int i = aw - 1; i >= 0; i--) begin
      drive_bit(sel, addr[i], m, o);
      if (o !== 1'b0) cmd_oe_bad++;
    end
    drive_bit(sel, rw, m, o);
    if (o !== 1'b0) cmd_oe_bad++;
    for (int w = 0; w < nwords; w++) begin
      rx_words[w] = '0;
      for (int b = dw - 1; b >= 0; b--) begin
        if (abort_bits >= 0 && sent == abort_bits) break;
        drive_bit(sel, tx_words[w][b], m, o);
        rx_words[w][b] = m;
        if (o !== logic'(rw)) oe_bad++;
        sent++;
      end
    end
    repeat (HALF) @(posedge clk);
    #1;
    set_cs(sel, 1'b1);
    repeat (2 * HALF) @(posedge clk);
    #1;
  endtask

  task automatic model_write(input int sel, input logic [31:0] addr, input int n, input logic fi);
    int          d;
    int          a;
    logic [31:0] w;
    d = (sel != 0) ? 10 : 128;
    a = int'(addr) % d;
    for (int i = 0; i < n; i++) begin
      w = tx_words[i] ^ {31'd0, fi};
      if (sel != 0) begin
        model_mem1[(a + i) % d] = w;
        model_leds1 = w[7:0];
      end else begin
        model_mem0[(a + i) % d] = w;
        model_leds0 = w[7:0];
      end
    end
  endtask

  function automatic logic [31:0] model_read(input int sel, input logic [31:0] addr, input int i);
    int d;
    int a;
    d = (sel != 0) ? 10 : 128;
    a = ((int'(addr) % d) + i) % d;
    return (sel != 0) ? model_mem1[a] : model_mem0[a];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    fault = 1'b0;
    cs0 = 1'b1;
    cs1 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({oe0, miso0, leds0} !== 10'h000)
      $display("[TB] FAIL reset_outputs0: got %h expected %h", {oe0, miso0, leds0}, 10'h000);
    else passes++;
    checks++;
    if ({oe1, miso1, leds1} !== 10'h000)
      $display("[TB] FAIL reset_outputs1: got %h expected %h", {oe1, miso1, leds1}, 10'h000);
    else passes++;
    reset = 1'b0;
    model_leds0 = 8'h00;
    model_leds1 = 8'h00;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_single_write_read();
    tx_words[0] = 32'hA7;
    spi_txn(0, 32'h05, 1'b0, 1, -1);
    model_write(0, 32'h05, 1, 1'b0);
    checks++;
    if (leds0 !== model_leds0) $display("[TB] FAIL single_leds: got %h expected %h", leds0, model_leds0);
    else passes++;
    checks++;
    if (oe_bad + cmd_oe_bad != 0) $display("[TB] FAIL write_oe: got %0d expected 0", oe_bad + cmd_oe_bad);
    else passes++;
    spi_txn(0, 32'h05, 1'b1, 1, -1);
    checks++;
    if (rx_words[0] !== model_read(0, 32'h05, 0))
      $display("[TB] FAIL single_read: got %h expected %h", rx_words[0], model_read(0, 32'h05, 0));
    else passes++;
    checks++;
    if (oe_bad != 0 || cmd_oe_bad != 0)
      $display("[TB] FAIL read_oe_window: got %0d/%0d expected 0/0", oe_bad, cmd_oe_bad);
    else passes++;
    checks++;
    if ({oe0, miso0} !== 2'b00) $display("[TB] FAIL oe_after_cs: got %b expected 00", {oe0, miso0});
    else passes++;
  endtask

  task automatic test_burst_wrap();
    tx_words[0] = 32'h11;
    tx_words[1] = 32'h22;
    tx_words[2] = 32'h33;
    spi_txn(0, 32'h7E, 1'b0, 3, -1);
    model_write(0, 32'h7E, 3, 1'b0);
    spi_txn(0, 32'h7E, 1'b1, 3, -1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_words[i] !== model_read(0, 32'h7E, i))
        $display("[TB] FAIL burst_wrap[%0d]: got %h expected %h", i, rx_words[i], model_read(0, 32'h7E, i));
      else passes++;
    end
    checks++;
    if (leds0 !== model_leds0) $display("[TB] FAIL burst_leds: got %h expected %h", leds0, model_leds0);
    else passes++;
  endtask

  task automatic test_fault_inject();
    fault = 1'b1;
    tx_words[0] = 32'h40;
    spi_txn(0, 32'h10, 1'b0, 1, -1);
    model_write(0, 32'h10, 1, 1'b1);
    fault = 1'b0;
    checks++;
    if (leds0 !== model_leds0) $display("[TB] FAIL fault_leds: got %h expected %h", leds0, model_leds0);
    else passes++;
    spi_txn(0, 32'h10, 1'b1, 1, -1);
    checks++;
    if (rx_words[0] !== model_read(0, 32'h10, 0))
      $display("[TB] FAIL fault_read: got %h expected %h", rx_words[0], model_read(0, 32'h10, 0));
    else passes++;
  endtask

  task automatic test_partial_write();
    tx_words[0] = 32'h5A;
    spi_txn(0, 32'h20, 1'b0, 1, -1);
    model_write(0, 32'h20, 1, 1'b0);
    tx_words[0] = 32'hC3;
    spi_txn(0, 32'h20, 1'b0, 1, 5);
    checks++;
    if (leds0 !== model_leds0) $display("[TB] FAIL partial_leds: got %h expected %h", leds0, model_leds0);
    else passes++;
    spi_txn(0, 32'h20, 1'b1, 1, -1);
    checks++;
    if (rx_words[0] !== model_read(0, 32'h20, 0))
      $display("[TB] FAIL partial_read: got %h expected %h", rx_words[0], model_read(0, 32'h20, 0));
    else passes++;
  endtask

  task automatic test_reset_mid_read();
    logic        m;
    logic        o;
    logic [31:0] a;
    a = 32'h33;
    tx_words[0] = 32'hFF;
    spi_txn(0, a, 1'b0, 1, -1);
    model_write(0, a, 1, 1'b0);
    cs0 = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
    for (int i = 6; i >= 0; i--) drive_bit(0, a[i], m, o);
    drive_bit(0, 1'b1, m, o);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b0, m, o);
    repeat (HALF / 2) @(posedge clk);
    #1;
    checks++;
    if ({oe0, miso0} !== 2'b11) $display("[TB] FAIL mid_read_drive: got %b expected 11", {oe0, miso0});
    else passes++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({oe0, miso0} !== 2'b00) $display("[TB] FAIL reset_mid_read: got %b expected 00", {oe0, miso0});
    else passes++;
    reset = 1'b0;
    model_leds0 = 8'h00;
    model_leds1 = 8'h00;
    cs0 = 1'b1;
    repeat (2 * HALF) @(posedge clk);
    #1;
    checks++;
    if (leds0 !== model_leds0) $display("[TB] FAIL reset_leds: got %h expected %h", leds0, model_leds0);
    else passes++;
    spi_txn(0, a, 1'b1, 1, -1);
    checks++;
    if (rx_words[0] !== model_read(0, a, 0))
      $display("[TB] FAIL post_reset_read: got %h expected %h", rx_words[0], model_read(0, a, 0));
    else passes++;
  endtask

  task automatic test_param_instance();
    tx_words[0] = 32'hBEEF;
    spi_txn(1, 32'd9, 1'b0, 1, -1);
    model_write(1, 32'd9, 1, 1'b0);
    checks++;
    if (leds1 !== model_leds1) $display("[TB] FAIL param_leds: got %h expected %h", leds1, model_leds1);
    else passes++;
    tx_words[1] = 32'($urandom_range(16'hFFFF, 0));
    spi_txn(1, 32'd9, 1'b0, 2, -1);
    model_write(1, 32'd9, 2, 1'b0);
    spi_txn(1, 32'd9, 1'b1, 2, -1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rx_words[i] !== model_read(1, 32'd9, i))
        $display("[TB] FAIL param_burst[%0d]: got %h expected %h", i, rx_words[i], model_read(1, 32'd9, i));
      else passes++;
    end
    tx_words[0] = 32'($urandom_range(16'hFFFF, 0));
    spi_txn(1, 32'd13, 1'b0, 1, -1);
    model_write(1, 32'd13, 1, 1'b0);
    spi_txn(1, 32'd3, 1'b1, 1, -1);
    checks++;
    if (rx_words[0] !== model_read(1, 32'd3, 0))
      $display("[TB] FAIL param_fold: got %h expected %h", rx_words[0], model_read(1, 32'd3, 0));
    else passes++;
    checks++;
    if (leds1 !== model_leds1) $display("[TB] FAIL param_leds2: got %h expected %h", leds1, model_leds1);
    else passes++;
  endtask

  task automatic test_random_bursts();
    logic [31:0] a;
    int          n;
    logic        fi;
    for (int it = 0; it < 4; it++) begin
      a = 32'($urandom_range(127, 0));
      n = int'($urandom_range(4, 1));
      fi = logic'($urandom_range(1, 0));
      for (int i = 0; i < n; i++) tx_words[i] = 32'($urandom_range(255, 0));
      fault = fi;
      spi_txn(0, a, 1'b0, n, -1);
      model_write(0, a, n, fi);
      fault = 1'b0;
      checks++;
      if (leds0 !== model_leds0) $display("[TB] FAIL rand_leds[%0d]: got %h expected %h", it, leds0, model_leds0);
      else passes++;
      spi_txn(0, a, 1'b1, n, -1);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (rx_words[i] !== model_read(0, a, i))
          $display("[TB] FAIL rand_read[%0d.%0d]: got %h expected %h", it, i, rx_words[i], model_read(0, a, i));
        else passes++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write_read();
    test_burst_wrap();
    test_fault_inject();
    test_partial_write();
    test_reset_mid_read();
    test_param_instance();
    test_random_bursts();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
